// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main controller: instruction-sequencing FSM plus datapath select/enable decode.
// Optional performance counters (cycle_cnt, instret_cnt) are built only when MCCTRL_PERF_EN is defined.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ResultSrc,
  output logic             illegal
`ifdef MCCTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  state_t     state_q, state_d;
  logic       mem_req_s, mem_write_s, ir_write_s, pc_write_s, reg_write_s, illegal_s;
  logic       instret_s;
  logic [2:0] alu_func_s;

  // State register; reset abandons any in-flight access and restarts at FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Immediate format follows the IR opcode in every state.
  always_comb begin
    ImmSrc = 3'd0;
    case (op)
      OP_BR:   ImmSrc = 3'd1;
      OP_SW:   ImmSrc = 3'd2;
      OP_JAL:  ImmSrc = 3'd3;
      OP_LUI:  ImmSrc = 3'd4;
      default: ImmSrc = 3'd0;
    endcase
  end

  // ALU operation for EXECR/EXECI; sub only for R-type with funct7b5, sra unsupported.
  always_comb begin
    alu_func_s = 3'd0;
    case (funct3)
      3'b000:  alu_func_s = ((state_q == S_EXECR) && funct7b5) ? 3'd1 : 3'd0;
      3'b111:  alu_func_s = 3'd2;
      3'b110:  alu_func_s = 3'd3;
      3'b100:  alu_func_s = 3'd4;
      3'b010:  alu_func_s = 3'd5;
      3'b001:  alu_func_s = 3'd6;
      3'b101:  alu_func_s = 3'd7;
      default: alu_func_s = 3'd0;
    endcase
  end

  // Next-state and state-decoded datapath controls.
  always_comb begin
    state_d     = state_q;
    mem_req_s   = 1'b0;
    AdrSrc      = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    reg_write_s = 1'b0;
    illegal_s   = 1'b0;
    instret_s   = 1'b0;
    ALUSrcA     = 2'd0;
    ALUSrcB     = 2'd0;
    ALUControl  = 3'd0;
    ResultSrc   = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_req_s  = 1'b1;
        ALUSrcB    = 2'd2;
        ResultSrc  = 2'd2;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd1;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'd2;
        ALUSrcB = 2'd1;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        AdrSrc    = 1'b1;
        state_d   = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc   = 2'd1;
        reg_write_s = 1'b1;
        instret_s   = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_s   = 1'b1;
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
        instret_s   = mem_ready;
        state_d     = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA    = 2'd2;
        ALUSrcB    = 2'd0;
        ALUControl = alu_func_s;
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'd2;
        ALUSrcB    = 2'd1;
        ALUControl = alu_func_s;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        instret_s   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'd2;
        ALUControl = 3'd1;
        pc_write_s = Zero ^ funct3[0];
        instret_s  = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'd1;
        ALUSrcB    = 2'd2;
        pc_write_s = 1'b1;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        ALUSrcA = 2'd3;
        ALUSrcB = 2'd1;
        state_d = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal_s = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are held low for as long as reset is asserted.
  assign mem_req  = mem_req_s & rst_n;
  assign MemWrite = mem_write_s & rst_n;
  assign IRWrite  = ir_write_s & rst_n;
  assign PCWrite  = pc_write_s & rst_n;
  assign RegWrite = reg_write_s & rst_n;
  assign illegal  = illegal_s & rst_n;

`ifdef MCCTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

  // Free-running counters that wrap naturally at their width.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    instret_cnt_d = instret_cnt_q;
    if (instret_s) begin
      instret_cnt_d = instret_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      instret_cnt_d = instret_cnt_q;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  logic unused_instret_s;
  assign unused_instret_s = instret_s;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed then random instructions checked per cycle against
// an instruction-level reference model that expands each instruction into its expected control cycles.
module tb_multicycle_control;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic funct7b5, Zero, mem_ready;
  logic mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, illegal;
  logic [2:0] ImmSrc, ALUControl;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
`ifdef MCCTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
`endif

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ResultSrc(ResultSrc), .illegal(illegal)
`ifdef MCCTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle_exp = 0;
  int instret_exp = 0;

  typedef struct {
    logic        rdy;
    logic [18:0] exp;
  } cyc_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, LUI = 7'b0110111, JALR = 7'b1100111;

  logic [18:0] obs;
  assign obs = {mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, illegal,
                ImmSrc, ALUSrcA, ALUSrcB, ALUControl, ResultSrc};

  // Reference cycle counter: counts clock edges taken with reset released.
  always @(posedge clk) cycle_exp <= rst_n ? cycle_exp + 1 : 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [18:0] vec(input logic mreq, adr, mw, irw, pcw, rw, ill,
                                      input logic [2:0] imm, input logic [1:0] a, b,
                                      input logic [2:0] alu, input logic [1:0] res);
    return {mreq, adr, mw, irw, pcw, rw, ill, imm, a, b, alu, res};
  endfunction

  // Instruction class: 0 lw,1 sw,2 R,3 I,4 branch,5 jal,6 lui,7 illegal.
  function automatic int cls(input logic [6:0] o);
    case (o)
      LW: return 0;  SW: return 1;  RT: return 2;  IT: return 3;
      BR: return 4;  JAL: return 5; LUI: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      BR: return 3'd1; SW: return 3'd2; JAL: return 3'd3; LUI: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000: return (is_r && f7) ? 3'd1 : 3'd0;
      3'b111: return 3'd2;
      3'b110: return 3'd3;
      3'b100: return 3'd4;
      3'b010: return 3'd5;
      3'b001: return 3'd6;
      3'b101: return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Expands one instruction into expected cycles and drives/checks up to 'limit' of them.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int fw, input int mw, input int limit);
    cyc_t q[$];
    int c;
    logic [2:0] im;
    logic rnd;
    c = cls(o);
    im = imm_of(o);
    for (int i = 0; i < fw; i++) q.push_back('{1'b0, vec(1,0,0,0,0,0,0,im,2'd0,2'd2,3'd0,2'd2)});
    q.push_back('{1'b1, vec(1,0,0,1,1,0,0,im,2'd0,2'd2,3'd0,2'd2)});
    rnd = 1'($urandom);
    q.push_back('{rnd, vec(0,0,0,0,0,0,0,im,2'd1,2'd1,3'd0,2'd0)});
    case (c)
      0, 1: begin
        rnd = 1'($urandom);
        q.push_back('{rnd, vec(0,0,0,0,0,0,0,im,2'd2,2'd1,3'd0,2'd0)});
        for (int i = 0; i <= mw; i++)
          q.push_back('{(i == mw), vec(1,1,(c == 1),0,0,0,0,im,2'd0,2'd0,3'd0,2'd0)});
        if (c == 0) begin
          rnd = 1'($urandom);
          q.push_back('{rnd, vec(0,0,0,0,0,1,0,im,2'd0,2'd0,3'd0,2'd1)});
        end
      end
      2, 3: begin
        rnd = 1'($urandom);
        q.push_back('{rnd, vec(0,0,0,0,0,0,0,im,2'd2,(c == 3) ? 2'd1 : 2'd0,
                               alu_of(f3, f7, (c == 2)),2'd0)});
      end
      4: begin
        rnd = 1'($urandom);
        q.push_back('{rnd, vec(0,0,0,0,z ^ f3[0],0,0,im,2'd2,2'd0,3'd1,2'd0)});
      end
      5: begin
        rnd = 1'($urandom);
        q.push_back('{rnd, vec(0,0,0,0,1,0,0,im,2'd1,2'd2,3'd0,2'd0)});
      end
      6: begin
        rnd = 1'($urandom);
        q.push_back('{rnd, vec(0,0,0,0,0,0,0,im,2'd3,2'd1,3'd0,2'd0)});
      end
      default: begin
        rnd = 1'($urandom);
        q.push_back('{rnd, vec(0,0,0,0,0,0,1,im,2'd0,2'd0,3'd0,2'd0)});
      end
    endcase
    if (c >= 2 && c <= 6 && c != 4) begin
      rnd = 1'($urandom);
      q.push_back('{rnd, vec(0,0,0,0,0,1,0,im,2'd0,2'd0,3'd0,2'd0)});
    end
    for (int i = 0; i < q.size() && i < limit; i++) begin
      op = o; funct3 = f3; funct7b5 = f7; Zero = z; mem_ready = q[i].rdy;
      #1;
      chk($sformatf("op%b_cyc%0d", o, i), 64'(obs), 64'(q[i].exp));
      @(posedge clk);
      @(negedge clk);
    end
    if (limit >= q.size() && c != 7) instret_exp++;
  endtask

  task automatic perf_chk(input string tag);
`ifdef MCCTRL_PERF_EN
    chk({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'(CNT_W'(cycle_exp)));
    chk({tag, "_instret_cnt"}, 64'(instret_cnt), 64'(CNT_W'(instret_exp)));
`endif
  endtask

  initial begin
    int k;
    logic [6:0] ops [8];
    ops = '{LW, SW, RT, IT, BR, JAL, LUI, JALR};
    rst_n = 1'b0; op = LW; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("reset_strobes", 64'({mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal}), 64'd0);
    perf_chk("reset");
    rst_n = 1'b1;

    run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0, 99);
    run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 3, 99);
    run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0, 99);
    run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0, 99);
    run_instr(RT, 3'b101, 1'b1, 1'b0, 2, 0, 99);
    run_instr(BR, 3'b001, 1'b0, 1'b0, 0, 0, 99);
    run_instr(BR, 3'b001, 1'b0, 1'b1, 0, 0, 99);
    run_instr(BR, 3'b000, 1'b0, 1'b1, 0, 0, 99);
    run_instr(JAL, 3'b000, 1'b0, 1'b0, 0, 0, 99);
    run_instr(LUI, 3'b000, 1'b0, 1'b0, 0, 0, 99);
    run_instr(JALR, 3'b000, 1'b0, 1'b0, 0, 0, 99);
    run_instr(LW, 3'b010, 1'b0, 1'b0, 1, 2, 99);
    perf_chk("directed");

    // Reset in the middle of a stalled load: run FETCH, DECODE, MEMADR and one MEMREAD cycle.
    run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 5, 4);
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("midreset_strobes", 64'({mem_req, MemWrite, IRWrite, PCWrite, RegWrite, illegal}), 64'd0);
    @(posedge clk); @(negedge clk);
    instret_exp = 0;
    perf_chk("after_reset");
    rst_n = 1'b1;
    run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 0, 99);

    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 8);
      run_instr((k == 8) ? 7'($urandom) : ops[k], 3'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), 99);
    end
    perf_chk("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
